// File: rtl/btn_event_arbiter.sv
// -----------------------------------------------------------------------------
// btn_event_arbiter
//
// Collects one-cycle press/repeat pulses from per-button debouncers. It keeps
// one pending request per button and serializes the requests round-robin into
// a small show-ahead event FIFO. The control FSM reads the FIFO with a
// valid/ready handshake and receives one button ID per transfer.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   btn_pulse   one-cycle event pulses, bit i = button i
//   btn_mask    1 = button enabled; 0 = pulses ignored and pending bit cleared
//   evt_valid   FIFO non-empty, evt_id is valid
//   evt_id      button index at the FIFO head
//   evt_ready   consumer accepts the head when evt_valid=1
//   pending     registered per-button pending bits
//   fifo_count  FIFO occupancy, 0..FIFO_DEPTH
//   drop        one-cycle pulse after a pulse merged into an already-pending
//               request
// -----------------------------------------------------------------------------
module btn_event_arbiter #(
  parameter  int N_BTN      = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int ID_W       = (N_BTN > 1) ? $clog2(N_BTN) : 1,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_pulse,
  input  logic [N_BTN-1:0] btn_mask,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  input  logic             evt_ready,
  output logic [N_BTN-1:0] pending,
  output logic [CNT_W-1:0] fifo_count,
  output logic             drop
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // State registers
  logic [N_BTN-1:0] pend_q,   pend_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             drop_q,   drop_d;
  logic [ID_W-1:0]  mem_q [FIFO_DEPTH];

  // Arbiter / FIFO control
  logic             fifo_full;
  logic             fifo_empty;
  logic             grant_vld;
  logic [ID_W-1:0]  grant_idx;
  logic [N_BTN-1:0] grant_oh;
  logic             push;
  logic             pop;

  // (base + ofs) mod N_BTN. This works for any N_BTN, including N_BTN values
  // that are not powers of two.
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base,
                                             input int              ofs);
    int sum;
    sum = int'(base) + ofs;
    if (sum >= N_BTN) sum -= N_BTN;
    return ID_W'(sum);
  endfunction

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // Round-robin search starts at rr_ptr_q. The fullness test uses the
  // registered count, so a pop in the same cycle does not free a slot for
  // this cycle's grant.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!fifo_full) begin
      for (int k = 0; k < N_BTN; k++) begin
        if (!grant_vld && pend_q[rr_idx(rr_ptr_q, k)]) begin
          grant_vld = 1'b1;
          grant_idx = rr_idx(rr_ptr_q, k);
        end
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (grant_vld) grant_oh[grant_idx] = 1'b1;
  end

  assign push = grant_vld;
  assign pop  = !fifo_empty && evt_ready;

  always_comb begin
    // A pulse that arrives in the same cycle as the grant starts a new
    // request. It is not counted as a drop.
    pend_d   = btn_mask & ((pend_q & ~grant_oh) | btn_pulse);
    drop_d   = |(btn_mask & btn_pulse & pend_q & ~grant_oh);
    rr_ptr_d = grant_vld ? rr_idx(grant_idx, 1) : rr_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values of all other flops.
    if (reset) begin
      pend_q   <= '0;
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // NOTE: the storage array has no reset. Its contents only become visible
  // through evt_id after a push has written them, and evt_id is forced to 0
  // while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= grant_idx;
  end

  assign evt_valid  = !fifo_empty;
  assign evt_id     = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign pending    = pend_q;
  assign fifo_count = count_q;
  assign drop       = drop_q;

endmodule

// File: doc/btn_event_arbiter.md
# btn_event_arbiter

Collects one-cycle press/repeat pulses from up to N_BTN debouncers, holds one pending request per button, and serializes them round-robin into a small show-ahead event FIFO. The game/control FSM reads the FIFO through a valid/ready handshake, one button ID per transfer. It sits between the per-button debouncers and the top-level control logic, so that simultaneous presses are never lost or merged.

## Interface
Parameters:
- N_BTN, 4: number of button inputs (≥1).
- FIFO_DEPTH, 4: event FIFO entries (power of two, ≥2).
- ID_W (localparam): $clog2(N_BTN), minimum 1.
- CNT_W (localparam): $clog2(FIFO_DEPTH+1).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- btn_pulse  in  N_BTN  one-cycle event pulses from the debouncers; bit i = button i.
- btn_mask  in  N_BTN  1 = button i enabled; 0 = its pulses are ignored and its pending bit is cleared.
- evt_valid  out  1  FIFO non-empty; evt_id is valid.
- evt_id  out  ID_W  button index at the FIFO head.
- evt_ready  in  1  consumer accepts the head when evt_valid=1.
- pending  out  N_BTN  registered pending bits.
- fifo_count  out  CNT_W  current FIFO occupancy, 0..FIFO_DEPTH.
- drop  out  1  one-cycle pulse when at least one button pulse was coalesced into an already-pending request.

## Operation
- **Pending bits:** next pend[i] = btn_mask[i] & ((pend[i] & ~grant[i]) | btn_pulse[i]).
  - Pulse on a masked-off button: ignored, no drop.
  - Pulse while pend[i]=1 and not granted that cycle: coalesced, and drop=1 next cycle.
  - Pulse in the same cycle pend[i] is granted: pend[i] stays 1 as a new request, no drop.
- **Arbiter:**
  - Grants are combinational from registered pend, at most one per cycle.
  - It grants only when fifo_count < FIFO_DEPTH. A same-cycle pop does not free space for that cycle's grant.
  - Search order: rr_ptr, rr_ptr+1, … mod N_BTN. The first pend bit that is set wins.
  - On a grant to index g: push g into the FIFO, clear pend[g], and set rr_ptr = (g+1) mod N_BTN.
  - No grant: rr_ptr holds.
- **FIFO:**
  - Circular buffer with wr_ptr and rd_ptr, both wrapping mod FIFO_DEPTH.
  - Pop when evt_valid & evt_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pop on empty and push on full cannot occur by construction.
- **Outputs:**
  - evt_valid = (fifo_count != 0).
  - evt_id = mem[rd_ptr] (show-ahead).
  - evt_id must not change while evt_valid=1 and evt_ready=0.
- **Reset** (synchronous, overrides everything, including pulses in the same cycle):
  - pend=0, rr_ptr=0, wr_ptr=rd_ptr=0, fifo_count=0.
  - Outputs: evt_valid=0, evt_id=0, drop=0, pending=0.
  - FIFO contents are discarded.
- **Mask while queued:** clearing btn_mask[i] does not remove entries already in the FIFO.

## Timing
- Pulse at edge t → pend[i]=1 after edge t+1 → granted during cycle t+1 → evt_valid=1 after edge t+2 (FIFO was empty, no contention). Pulse-to-valid latency is 2 cycles.
- Throughput: one push and one pop per cycle sustained.
- drop is registered and asserts in the cycle after the coalesced pulse.
- fifo_count and pending reflect state after the most recent edge.
- No combinational path from btn_pulse or evt_ready to evt_valid or evt_id.

## Test plan
- **Reset:** assert reset for 2 cycles with btn_pulse=4'b1111 → evt_valid=0, pending=0, fifo_count=0, drop=0 throughout; after release, no events.
- **Single press:** evt_ready=1, mask=4'b1111, pulse btn 2 at cycle t → evt_valid=1 with evt_id=2 exactly at t+2 for one cycle; fifo_count returns to 0.
- **Simultaneous press:** evt_ready=0, pulse 4'b1011 in one cycle → FIFO holds IDs 0,1,3 in order. Then pulse 4'b0011 → next IDs are 0,1, with rr_ptr continuing from 0. Raise ready and verify the pop order 0,1,3,0,1.
- **Full/backpressure:** evt_ready=0, DEPTH=4. Pulse 4'b1111, then pulse 4'b0001 again after 6 cycles → fifo_count=4, pending=4'b0001. Pop one → ID 0 granted the next cycle, fifo_count back to 4.
- **Coalesce/drop:** evt_ready=0, FIFO full, pend[1]=1; pulse btn 1 → drop=1 for exactly one cycle, pending unchanged. Pulse btn 1 in the same cycle its grant occurs → no drop, pend[1]=1 afterwards.
- **Mask:** pend[3]=1, then drive btn_mask[3]=0 → pending[3]=0 next cycle and no ID 3 is pushed. Pulses on btn 3 while masked → no pending, no drop.
